// File: rtl/piezo_pkg.sv
// rtl/piezo_pkg.sv - shared types, state codes and default alarm melody for the piezo sequencer
package piezo_pkg;

  typedef enum logic [2:0] {
    NOTE_C4 = 3'd0,
    NOTE_D4 = 3'd1,
    NOTE_E4 = 3'd2,
    NOTE_F4 = 3'd3,
    NOTE_G4 = 3'd4,
    NOTE_A4 = 3'd5,
    NOTE_B4 = 3'd6,
    NOTE_C5 = 3'd7
  } note_e;

  typedef struct packed {
    logic       rest;
    logic [2:0] note;
    logic [2:0] dur;
  } mel_entry_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] TONE = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  // Longest ROM any instance may ask for; entries past the melody are zero, i.e. end markers.
  localparam int MEL_MAX = 64;

  localparam logic [6:0] ENT_E4_1   = {1'b0, NOTE_E4, 3'd1};
  localparam logic [6:0] ENT_G4_1   = {1'b0, NOTE_G4, 3'd1};
  localparam logic [6:0] ENT_REST_1 = {1'b1, NOTE_C4, 3'd1};
  localparam logic [6:0] ENT_C5_2   = {1'b0, NOTE_C5, 3'd2};

  localparam logic [7*MEL_MAX-1:0] MELODY_DEFAULT =
    {{(7*(MEL_MAX-4)){1'b0}}, ENT_C5_2, ENT_REST_1, ENT_G4_1, ENT_E4_1};

  function automatic logic [7:0] note_onehot(input logic [2:0] n);
    return 8'b1 << n;
  endfunction

endpackage

// File: rtl/piezo_beat_timer.sv
// rtl/piezo_beat_timer.sv - loadable down-counter; expired is high while the count sits at zero
module piezo_beat_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/piezo_melody_ctrl.sv
// rtl/piezo_melody_ctrl.sv - melody sequencer / manual-button arbiter for the 8-voice piezo tone bank
// Optional PIEZO_MELODY_LOOP_EN adds a loop input that replays the melody until aborted.
module piezo_melody_ctrl
  import piezo_pkg::*;
#(
  parameter int                   BEAT_CYCLES = 250000,
  parameter int                   GAP_CYCLES  = 20000,
  parameter int                   MEL_LEN     = 16,
  parameter logic [7*MEL_LEN-1:0] MELODY      = MELODY_DEFAULT[7*MEL_LEN-1:0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
`ifdef PIEZO_MELODY_LOOP_EN
  input  logic       loop,
`endif
  input  logic [7:0] button,
  output logic [7:0] note_en,
  output logic       busy,
  output logic       done
);

  localparam int TW    = $clog2(7*BEAT_CYCLES+1);
  localparam int IDX_W = (MEL_LEN > 1) ? $clog2(MEL_LEN) : 1;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       note_en_q, note_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lockout_q, lockout_d;

  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_expired;
  logic             loop_en;
  mel_entry_t       entry;

`ifdef PIEZO_MELODY_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign entry = MELODY[7*int'(idx_q) +: 7];

  piezo_beat_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    note_en_d = note_en_q;
    done_d    = 1'b0;
    lockout_d = lockout_q & (button != 8'd0);
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          idx_d     = '0;
          note_en_d = 8'd0;
        end else if (lockout_q) begin
          note_en_d = 8'd0;
        end else begin
          note_en_d = button & (~button + 8'd1);
        end
      end
      LOAD: begin
        if (entry.dur == 3'd0) begin
          idx_d   = '0;
          state_d = loop_en ? LOAD : IDLE;
          done_d  = ~loop_en;
        end else begin
          state_d   = TONE;
          tmr_load  = 1'b1;
          tmr_val   = TW'(entry.dur) * TW'(BEAT_CYCLES) - TW'(1);
          note_en_d = entry.rest ? 8'd0 : note_onehot(entry.note);
        end
      end
      TONE: begin
        if (tmr_expired) begin
          state_d   = GAP;
          note_en_d = 8'd0;
          tmr_load  = 1'b1;
          tmr_val   = TW'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (tmr_expired) begin
          if (idx_q == IDX_W'(MEL_LEN - 1)) begin
            idx_d   = '0;
            state_d = loop_en ? LOAD : IDLE;
            done_d  = ~loop_en;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Any stop or button press while the melody owns the bank silences it; a button abort
    // also locks out manual mode until every button has been released.
    if (state_q != IDLE && (stop || button != 8'd0)) begin
      state_d   = IDLE;
      idx_d     = '0;
      note_en_d = 8'd0;
      done_d    = 1'b0;
      tmr_load  = 1'b0;
      lockout_d = (button != 8'd0);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      note_en_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      note_en_q <= note_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lockout_q <= lockout_d;
    end
  end

  assign note_en = note_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_piezo_melody_ctrl.sv
// tb/tb_piezo_melody_ctrl.sv - directed self-checking bench for piezo_melody_ctrl
module tb_piezo_melody_ctrl;

  localparam int BEAT = 10;
  localparam int GAPC = 2;
  localparam int MLEN = 16;
  localparam logic [7*MLEN-1:0] ROM_NO_END = {MLEN{7'b0010001}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] button = 8'd0;
  logic [7:0] note_en;
  logic       busy;
  logic       done;

  logic       start2 = 1'b0;
  logic [7:0] note_en2;
  logic       busy2;
  logic       done2;

`ifdef PIEZO_MELODY_LOOP_EN
  logic       loop = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piezo_melody_ctrl #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .MEL_LEN(MLEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
`ifdef PIEZO_MELODY_LOOP_EN
    .loop    (loop),
`endif
    .button  (button),
    .note_en (note_en),
    .busy    (busy),
    .done    (done)
  );

  piezo_melody_ctrl #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .MEL_LEN(MLEN), .MELODY(ROM_NO_END)) dut_noend (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .stop    (1'b0),
`ifdef PIEZO_MELODY_LOOP_EN
    .loop    (1'b0),
`endif
    .button  (8'd0),
    .note_en (note_en2),
    .busy    (busy2),
    .done    (done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (note_en !== 8'd0) begin errors++; $display("FAIL reset_note_en got %h want 00", note_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_melody();
    logic [7:0] exp_note;
    logic       exp_busy;
    logic       exp_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      exp_note = (c >= 2 && c <= 11)  ? 8'h04 :
                 (c >= 15 && c <= 24) ? 8'h10 :
                 (c >= 41 && c <= 60) ? 8'h80 : 8'h00;
      exp_busy = (c >= 1 && c <= 63);
      exp_done = (c == 64);
      checks++; if (note_en !== exp_note) begin errors++; $display("FAIL melody_note c=%0d got %h want %h", c, note_en, exp_note); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL melody_busy c=%0d got %b want %b", c, busy, exp_busy); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL melody_done c=%0d got %b want %b", c, done, exp_done); end
      tick();
    end
  endtask

  task automatic test_manual();
    button = 8'b0010_0100;
    tick();
    checks++; if (note_en !== 8'h04) begin errors++; $display("FAIL manual_lowest got %h want 04", note_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL manual_busy got %b want 0", busy); end
    button = 8'h80;
    tick();
    checks++; if (note_en !== 8'h80) begin errors++; $display("FAIL manual_c5 got %h want 80", note_en); end
    button = 8'h00;
    tick();
    checks++; if (note_en !== 8'h00) begin errors++; $display("FAIL manual_release got %h want 00", note_en); end
    stop = 1'b1;
    button = 8'h08;
    tick();
    checks++; if (note_en !== 8'h08) begin errors++; $display("FAIL manual_with_stop got %h want 08", note_en); end
    stop = 1'b0;
    button = 8'h00;
    tick();
  endtask

  task automatic test_button_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++; if (note_en !== 8'h04) begin errors++; $display("FAIL abort_pre_note got %h want 04", note_en); end
    button = 8'h40;
    tick();
    checks++; if (note_en !== 8'h00) begin errors++; $display("FAIL abort_note got %h want 00", note_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (note_en !== 8'h00) begin errors++; $display("FAIL lockout_held i=%0d got %h want 00", i, note_en); end
    end
    button = 8'h00;
    tick();
    button = 8'h40;
    tick();
    checks++; if (note_en !== 8'h40) begin errors++; $display("FAIL lockout_cleared got %h want 40", note_en); end
    button = 8'h00;
    tick();
  endtask

  task automatic test_stop_gap();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    checks++; if (note_en !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL gap_pre got note %h busy %b want 00 1", note_en, busy); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_no_done i=%0d got %b want 0", i, done); end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (note_en !== 8'h04) begin errors++; $display("FAIL replay_first got %h want 04", note_en); end
    repeat (13) tick();
    checks++; if (note_en !== 8'h10) begin errors++; $display("FAIL replay_second got %h want 10", note_en); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_start_with_button();
    start = 1'b1;
    button = 8'h02;
    tick();
    start = 1'b0;
    button = 8'h00;
    checks++; if (busy !== 1'b1 || note_en !== 8'h00) begin errors++; $display("FAIL start_wins got busy %b note %h want 1 00", busy, note_en); end
    tick();
    checks++; if (note_en !== 8'h04) begin errors++; $display("FAIL start_wins_first got %h want 04", note_en); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    start = 1'b1;
    button = 8'h02;
    tick();
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || note_en !== 8'h00) begin errors++; $display("FAIL load_abort got busy %b note %h want 0 00", busy, note_en); end
    button = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_note();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++; if (note_en !== 8'h04) begin errors++; $display("FAIL midnote_pre got %h want 04", note_en); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (note_en !== 8'h00) begin errors++; $display("FAIL async_reset_note got %h want 00", note_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b want 0", busy); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_no_end_marker();
    int ndone;
    ndone = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 215; c++) begin
      if (done2 === 1'b1) ndone++;
      if (c == 197) begin
        checks++; if (note_en2 !== 8'h04) begin errors++; $display("FAIL noend_last_note got %h want 04", note_en2); end
      end
      if (c == 208) begin
        checks++; if (busy2 !== 1'b1 || done2 !== 1'b0) begin errors++; $display("FAIL noend_last_gap got busy %b done %b want 1 0", busy2, done2); end
      end
      if (c == 209) begin
        checks++; if (busy2 !== 1'b0 || done2 !== 1'b1) begin errors++; $display("FAIL noend_done got busy %b done %b want 0 1", busy2, done2); end
      end
      tick();
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL noend_done_count got %0d want 1", ndone); end
  endtask

`ifdef PIEZO_MELODY_LOOP_EN
  task automatic test_loop();
    int ndone;
    ndone = 0;
    loop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      if (c == 64) begin
        checks++; if (note_en !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL loop_reload got note %h busy %b want 00 1", note_en, busy); end
      end
      if (c == 65) begin
        checks++; if (note_en !== 8'h04) begin errors++; $display("FAIL loop_second_e4 got %h want 04", note_en); end
        loop = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        checks++; if (c != 127) begin errors++; $display("FAIL loop_done_cycle got %0d want 127", c); end
      end
      tick();
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL loop_done_count got %0d want 1", ndone); end
  endtask
`endif

  initial begin
    test_reset();
    test_melody();
    test_manual();
    test_button_abort();
    test_stop_gap();
    test_start_with_button();
    test_reset_mid_note();
    test_no_end_marker();
`ifdef PIEZO_MELODY_LOOP_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
